// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the Wishbone port-size converter.
// Beat/lane arithmetic lives here so the finder and top agree on it.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } rsp_e;

  function automatic int beat_count(
    input int master_w,
    input int slave_w
  );
    return master_w / slave_w;
  endfunction

  function automatic int lanes_per_beat(
    input int slave_w,
    input int gran
  );
    return slave_w / gran;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // SEL bits of master lane group k, l lanes per group
  function automatic logic [63:0] lane_mask(
    input int k,
    input int l
  );
    return ((64'd1 << l) - 64'd1) << (k * l);
  endfunction

endpackage

// File: rtl/wishbone.sv
// Wishbone classic bus bundle with master/slave views.
// dat_ms flows master to slave, dat_sm flows slave to master.
interface wishbone #(
  parameter int ADR_BITS    = 16,
  parameter int DAT_BITS    = 32,
  parameter int GRANULARITY = 8
);
  localparam int SEL_BITS = DAT_BITS / GRANULARITY;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADR_BITS-1:0] adr;
  logic [DAT_BITS-1:0] dat_ms;
  logic [DAT_BITS-1:0] dat_sm;
  logic [SEL_BITS-1:0] sel;
  logic                ack;
  logic                err;
  logic                rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wb_beat_finder.sv
// Priority encoder: lowest beat index >= from_i that should be issued.
// With skipping off every beat qualifies, so only the range matters.
module wb_beat_finder
  import wb_pkg::*;
#(
  parameter int N    = 4,
  parameter int L    = 1,
  parameter int SKIP = 1,
  parameter int KW   = 2
) (
  input  logic [N*L-1:0] sel_i,
  input  logic [KW:0]    from_i,
  output logic [KW-1:0]  k_o,
  output logic           found_o
);

  always_comb begin
    k_o     = '0;
    found_o = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if ((j >= int'(from_i)) &&
          ((SKIP == 0) ||
           ((64'(sel_i) & lane_mask(j, L)) != 64'd0))) begin
        k_o     = KW'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_downsizer.sv
// Wide-master to narrow-slave Wishbone converter: one master cycle
// becomes a locked run of slave beats, read data reassembled per lane.
module wb_downsizer
  import wb_pkg::*;
#(
  parameter int MASTER_ADR_BITS  = 16,
  parameter int MASTER_PORT_SIZE = 32,
  parameter int SLAVE_ADR_BITS   = 16,
  parameter int SLAVE_PORT_SIZE  = 8,
  parameter int GRANULARITY      = 8,
  parameter int SKIP_EMPTY_BEATS = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wishbone.slave   master_m,
  wishbone.master  slave_s
);

  localparam int N =
    beat_count(MASTER_PORT_SIZE, SLAVE_PORT_SIZE);
  localparam int L =
    lanes_per_beat(SLAVE_PORT_SIZE, GRANULARITY);
  localparam int MSEL = MASTER_PORT_SIZE / GRANULARITY;
  localparam int SSEL = L;
  localparam int KW   = idx_bits(N);
  localparam int AB   = idx_bits(MSEL);
  localparam int AW   =
    (MASTER_ADR_BITS > SLAVE_ADR_BITS) ?
    MASTER_ADR_BITS : SLAVE_ADR_BITS;

  localparam int MAB = MASTER_ADR_BITS;
  localparam int SAB = SLAVE_ADR_BITS;
  localparam int MPS = MASTER_PORT_SIZE;
  localparam int SPS = SLAVE_PORT_SIZE;

  state_e          state_q, state_d;
  rsp_e            rsp_q, rsp_d;
  logic [MAB-1:0]  adr_q, adr_d;
  logic            we_q, we_d;
  logic [MPS-1:0]  dat_q, dat_d;
  logic [MSEL-1:0] sel_q, sel_d;
  logic [KW-1:0]   k_q, k_d;
  logic [MPS-1:0]  rd_q, rd_d;

  logic            s_cyc_q, s_cyc_d;
  logic            s_stb_q, s_stb_d;
  logic            s_we_q, s_we_d;
  logic [SAB-1:0]  s_adr_q, s_adr_d;
  logic [SSEL-1:0] s_sel_q, s_sel_d;
  logic [SPS-1:0]  s_dat_q, s_dat_d;

  logic            idle;
  logic            req;
  logic [MAB-1:0]  src_adr;
  logic            src_we;
  logic [MPS-1:0]  src_dat;
  logic [MSEL-1:0] src_sel;
  logic [KW:0]     from;
  logic [KW-1:0]   kf;
  logic            found;
  logic [KW-1:0]   kb;
  logic            issue;

  // Master word base (lane bits cleared) plus the beat's lane offset
  function automatic logic [SAB-1:0] beat_adr(
    input logic [MAB-1:0] a,
    input logic [KW-1:0]  k
  );
    logic [AW-1:0] base;
    base = AW'(a >> AB) << AB;
    base = base + AW'(k) * AW'(L);
    return SAB'(base);
  endfunction

  function automatic logic [SSEL-1:0] beat_sel(
    input logic [MSEL-1:0] s,
    input logic [KW-1:0]   k
  );
    return s[int'(k)*L +: L];
  endfunction

  function automatic logic [SPS-1:0] beat_dat(
    input logic [MPS-1:0] d,
    input logic [KW-1:0]  k
  );
    return d[int'(k)*SPS +: SPS];
  endfunction

  assign idle = (state_q == ST_IDLE);
  assign req  = master_m.cyc & master_m.stb;

  assign src_adr = idle ? master_m.adr    : adr_q;
  assign src_we  = idle ? master_m.we     : we_q;
  assign src_dat = idle ? master_m.dat_ms : dat_q;
  assign src_sel = idle ? master_m.sel    : sel_q;

  assign from = idle ? '0 :
                ({1'b0, k_q} + (KW+1)'(1));

  wb_beat_finder #(
    .N    (N),
    .L    (L),
    .SKIP (SKIP_EMPTY_BEATS),
    .KW   (KW)
  ) u_finder (
    .sel_i   (src_sel),
    .from_i  (from),
    .k_o     (kf),
    .found_o (found)
  );

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    k_d     = k_q;
    rd_d    = rd_q;
    s_cyc_d = 1'b0;
    s_stb_d = 1'b0;
    s_we_d  = 1'b0;
    s_adr_d = '0;
    s_sel_d = '0;
    s_dat_d = '0;
    kb      = kf;
    issue   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d = master_m.adr;
          we_d  = master_m.we;
          dat_d = master_m.dat_ms;
          sel_d = master_m.sel;
          rd_d  = '0;
          if (found) begin
            state_d = ST_BEAT;
            k_d     = kf;
            issue   = 1'b1;
          end else begin
            state_d = ST_RESP;
            rsp_d   = RSP_ACK;
          end
        end
      end
      ST_BEAT: begin
        if (!master_m.cyc) begin
          state_d = ST_IDLE;
        end else if (slave_s.err) begin
          state_d = ST_RESP;
          rsp_d   = RSP_ERR;
        end else if (slave_s.rty) begin
          state_d = ST_RESP;
          rsp_d   = RSP_RTY;
        end else if (slave_s.ack) begin
          if (!we_q) begin
            rd_d[int'(k_q)*SPS +: SPS] = slave_s.dat_sm;
          end
          if (found) begin
            k_d   = kf;
            issue = 1'b1;
          end else begin
            state_d = ST_RESP;
            rsp_d   = RSP_ACK;
          end
        end else begin
          kb    = k_q;
          issue = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue) begin
      s_cyc_d = 1'b1;
      s_stb_d = 1'b1;
      s_we_d  = src_we;
      s_adr_d = beat_adr(src_adr, kb);
      s_sel_d = beat_sel(src_sel, kb);
      s_dat_d = beat_dat(src_dat, kb);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rsp_q   <= RSP_ACK;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      k_q     <= '0;
      rd_q    <= '0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_sel_q <= '0;
      s_dat_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_adr_q <= s_adr_d;
      s_sel_q <= s_sel_d;
      s_dat_q <= s_dat_d;
    end
  end

  assign slave_s.cyc    = s_cyc_q;
  assign slave_s.stb    = s_stb_q;
  assign slave_s.we     = s_we_q;
  assign slave_s.adr    = s_adr_q;
  assign slave_s.sel    = s_sel_q;
  assign slave_s.dat_ms = s_dat_q;

  assign master_m.ack =
    (state_q == ST_RESP) && (rsp_q == RSP_ACK);
  assign master_m.err =
    (state_q == ST_RESP) && (rsp_q == RSP_ERR);
  assign master_m.rty =
    (state_q == ST_RESP) && (rsp_q == RSP_RTY);
  assign master_m.dat_sm =
    (state_q == ST_RESP) ? rd_q : '0;

endmodule
